// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiply sequencer: ALU op codes and FSM states.
package alu_mul_sequencer_pkg;

  // ALU op encoding: bit2 inverts operand b, bits1:0 select the function.
  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Unsigned shift-add multiplier (low word) that borrows the shared ALU adder,
// one multiplier bit per cycle, while the core is stalled on busy.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_zero,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_r
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_zero_q, result_zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             alu_own_q, alu_own_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             last_iter;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d       = state_q;
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    count_d       = count_q;
    result_d      = result_q;
    result_zero_d = result_zero_q;
    last_iter     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          count_d  = '0;
          state_d  = ST_ITER;
        end
      end

      ST_ITER: begin
        acc_d    = mplier_q[0] ? alu_r : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        last_iter = (count_q == LAST_CNT) ||
                    (EARLY_EXIT && ((mplier_q >> 1) == '0));
        if (last_iter) begin
          // Hold count on the final step so it never wraps past WIDTH-1.
          result_d      = acc_d;
          result_zero_d = (acc_d == '0);
          state_d       = ST_DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the next state so they align with it.
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    alu_own_d = (state_d == ST_ITER);
    alu_op_d  = alu_own_d ? ALUOP_ADD : ALUOP_AND;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      count_q       <= '0;
      result_q      <= '0;
      result_zero_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      alu_own_q     <= 1'b0;
      alu_op_q      <= ALUOP_AND;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      count_q       <= count_d;
      result_q      <= result_d;
      result_zero_q <= result_zero_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      alu_own_q     <= alu_own_d;
      alu_op_q      <= alu_op_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign result_zero = result_zero_q;
  assign alu_own     = alu_own_q;
  assign alu_op      = alu_op_q;
  assign alu_cin     = 1'b0;

  // Operand lines are quiet whenever the sequencer does not own the ALU.
  assign alu_a = alu_own_q ? acc_q   : '0;
  assign alu_b = alu_own_q ? mcand_q : '0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench: two sequencers (early exit on/off) share stimulus, each
// paired with a behavioural ALU behind an alu_own-controlled input mux.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    int           n;
    int           acc_edge;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [W-1:0] core_a = 32'h0F0F_1234;
  logic [W-1:0] core_b = 32'h00FF_0001;

  logic         busy_e, done_e, rz_e, own_e, cin_e;
  logic [W-1:0] res_e, a_e, b_e, r_e;
  logic [2:0]   op_e;
  logic         busy_f, done_f, rz_f, own_f, cin_f;
  logic [W-1:0] res_f, a_f, b_f, r_f;
  logic [2:0]   op_f;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t sb[2][$];
  int   free_edge[2];
  int   own_cnt[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op, input logic cin);
    logic [W-1:0] bb;
    bb = op[2] ? ~b : b;
    case (op[1:0])
      2'b00:   return a & bb;
      2'b01:   return a | bb;
      2'b10:   return a + bb + {{(W-1){1'b0}}, cin};
      default: return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
    endcase
  endfunction

  // Top-level ALU input mux: the core drives an OR unless the sequencer owns it.
  assign r_e = own_e ? alu_model(a_e, b_e, op_e, cin_e) : alu_model(core_a, core_b, ALUOP_OR, 1'b0);
  assign r_f = own_f ? alu_model(a_f, b_f, op_f, cin_f) : alu_model(core_a, core_b, ALUOP_OR, 1'b0);

  alu_mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_early (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy_e), .done(done_e), .result(res_e), .result_zero(rz_e),
    .alu_own(own_e), .alu_a(a_e), .alu_b(b_e), .alu_op(op_e), .alu_cin(cin_e),
    .alu_r(r_e)
  );

  alu_mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy_f), .done(done_f), .result(res_f), .result_zero(rz_f),
    .alu_own(own_f), .alu_a(a_f), .alu_b(b_f), .alu_op(op_f), .alu_cin(cin_f),
    .alu_r(r_f)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Iteration count from the multiplier's highest set bit.
  function automatic int n_iter(input logic [W-1:0] b, input bit ee);
    int hi;
    if (!ee) return W;
    hi = 0;
    for (int i = 0; i < W; i++) if (b[i]) hi = i + 1;
    return (hi == 0) ? 1 : hi;
  endfunction

  // Drive one cycle of inputs and predict, per instance, whether start is taken.
  task automatic drive(input bit s, input bit r, input logic [W-1:0] a, input logic [W-1:0] b);
    int   e;
    exp_t x;
    logic [63:0] prod;
    @(negedge clk);
    reset = r;
    start = s && !r;
    op_a  = a;
    op_b  = b;
    e = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        sb[i].delete();
        free_edge[i] = e + 1;
      end else if (s && e >= free_edge[i]) begin
        prod       = {32'h0, a} * {32'h0, b};
        x.res      = prod[W-1:0];
        x.n        = n_iter(b, (i == 0));
        x.acc_edge = e;
        sb[i].push_back(x);
        free_edge[i] = e + x.n + 2;
      end
    end
  endtask

  task automatic wait_free();
    int guard = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      guard++;
    end while (!(cyc + 1 >= free_edge[0] && cyc + 1 >= free_edge[1]) && guard < 200);
    if (guard >= 200) check("wait_free_timeout", 64'(guard), 64'd0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_free();
    drive(1'b1, 1'b0, a, b);
  endtask

  task automatic mon(input int i, input logic busy, input logic done, input logic own,
                     input logic [W-1:0] res, input logic rz, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [2:0] op, input logic cin);
    string t;
    exp_t  x;
    t = (i == 0) ? "ee1" : "ee0";
    if (reset) begin
      own_cnt[i] = 0;
      check({t, "_rst_busy"}, 64'(busy), 64'd0);
      check({t, "_rst_done"}, 64'(done), 64'd0);
      check({t, "_rst_own"}, 64'(own), 64'd0);
      check({t, "_rst_result"}, 64'(res), 64'd0);
      check({t, "_rst_zero"}, 64'(rz), 64'd1);
      return;
    end
    if (own) begin
      own_cnt[i]++;
      check({t, "_iter_op"}, 64'({op, cin}), 64'({ALUOP_ADD, 1'b0}));
    end
    if (!busy) check({t, "_idle_lines"}, 64'({own, op, (a != '0), (b != '0)}), 64'd0);
    if (done) begin
      if (sb[i].size() == 0) begin
        check({t, "_spurious_done"}, 64'd1, 64'd0);
      end else begin
        x = sb[i].pop_front();
        check({t, "_result"}, 64'(res), 64'(x.res));
        check({t, "_result_zero"}, 64'(rz), 64'(x.res == '0));
        check({t, "_done_busy_own"}, 64'({busy, own}), 64'b10);
        check({t, "_latency"}, 64'(cyc - x.acc_edge), 64'(x.n));
        check({t, "_iter_cycles"}, 64'(own_cnt[i]), 64'(x.n));
      end
      own_cnt[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, busy_e, done_e, own_e, res_e, rz_e, a_e, b_e, op_e, cin_e);
    mon(1, busy_f, done_f, own_f, res_f, rz_f, a_f, b_f, op_f, cin_f);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rb;
    free_edge[0] = 0;
    free_edge[1] = 0;
    own_cnt[0] = 0;
    own_cnt[1] = 0;
    repeat (3) drive(1'b0, 1'b1, '0, '0);
    repeat (2) drive(1'b0, 1'b0, '0, '0);

    issue(32'd7, 32'd3);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(32'h1234, 32'h0);

    // Requests while busy, including the DONE cycle, must be dropped.
    issue(32'd5, 32'd6);
    repeat (4) drive(1'b1, 1'b0, 32'd9, 32'd9);

    // Reset ten cycles into a long multiply, then a fresh one.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) drive(1'b0, 1'b0, $urandom, $urandom);
    drive(1'b0, 1'b1, '0, '0);
    drive(1'b0, 1'b0, '0, '0);
    issue(32'd4, 32'd4);

    issue(32'd3, 32'd1);

    for (int c = 0; c < 700; c++) begin
      case ($urandom_range(0, 3))
        0:       rb = W'($urandom_range(0, 15));
        1:       rb = $urandom;
        2:       rb = '0;
        default: rb = W'(1) << $urandom_range(0, W - 1);
      endcase
      core_a = $urandom;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0, $urandom, rb);
    end

    wait_free();
    repeat (3) drive(1'b0, 1'b0, '0, '0);
    check("ee1_drained", 64'(sb[0].size()), 64'd0);
    check("ee0_drained", 64'(sb[1].size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
